// File: rtl/assoc_cache_memory_system.sv
// N-way set-associative, write-back, write-allocate cache with LRU replacement,
// fronting an internal word-addressed backing memory with a per-word latency.
module assoc_cache_memory_system #(
  parameter int data_length    = 32,
  parameter int address_length = 10,
  parameter int WAYS           = 2,
  parameter int SETS           = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_LATENCY    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [address_length-1:0] address,
  input  logic [data_length-1:0]    DataIn,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  output logic                      stall,
  output logic [data_length-1:0]    DataOut,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count,
  output logic [31:0]               writeback_count
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = address_length - OFF_W - IDX_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2} state_t;

  state_t                 state_r, state_n_s;
  logic [data_length-1:0] line_data_r [WAYS][SETS][WORDS_PER_LINE];
  logic [TAG_W-1:0]       tag_r [SETS][WAYS];
  logic                   valid_r [SETS][WAYS];
  logic                   dirty_r [SETS][WAYS];
  logic [WAY_W-1:0]       age_r [SETS][WAYS];
  logic [data_length-1:0] bmem_r [2**address_length];

  logic [WAY_W-1:0]       victim_r;
  logic                   retry_r;
  logic [LAT_W-1:0]       lat_cnt_r;
  logic [OFF_W-1:0]       word_cnt_r;

  logic [OFF_W-1:0]       offset_s;
  logic [IDX_W-1:0]       index_s;
  logic [TAG_W-1:0]       tag_s;
  logic                   req_s, hit_s, all_valid_s, word_end_s, last_s, lru_upd_s;
  logic [WAYS-1:0]        match_s;
  logic [WAY_W-1:0]       hit_way_s, free_way_s, lru_way_s, victim_s, acc_way_s;
  logic [WAY_W-1:0]       age_n_s [WAYS];
  logic [address_length-1:0] wb_addr_s, rf_addr_s;

  assign offset_s   = address[OFF_W-1:0];
  assign index_s    = address[OFF_W +: IDX_W];
  assign tag_s      = address[address_length-1 -: TAG_W];
  assign req_s      = MemRead | MemWrite;
  assign word_end_s = (lat_cnt_r == LAT_W'(MEM_LATENCY - 1));
  assign last_s     = word_end_s && (word_cnt_r == OFF_W'(WORDS_PER_LINE - 1));
  assign wb_addr_s  = {tag_r[index_s][victim_r], index_s, word_cnt_r};
  assign rf_addr_s  = {tag_s, index_s, word_cnt_r};

  // Tag lookup, victim choice and the LRU ages resulting from the current access.
  always_comb begin
    match_s     = '0;
    hit_way_s   = '0;
    free_way_s  = '0;
    lru_way_s   = '0;
    all_valid_s = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match_s[w]  = valid_r[index_s][w] && (tag_r[index_s][w] == tag_s);
      hit_way_s   = match_s[w] ? WAY_W'(w) : hit_way_s;
      free_way_s  = valid_r[index_s][w] ? free_way_s : WAY_W'(w);
      lru_way_s   = (age_r[index_s][w] == WAY_W'(WAYS - 1)) ? WAY_W'(w) : lru_way_s;
      all_valid_s = all_valid_s & valid_r[index_s][w];
    end
    hit_s     = |match_s;
    victim_s  = all_valid_s ? lru_way_s : free_way_s;
    acc_way_s = (state_r == REFILL) ? victim_r : hit_way_s;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == acc_way_s) begin
        age_n_s[w] = '0;
      end else if (age_r[index_s][w] < age_r[index_s][acc_way_s]) begin
        age_n_s[w] = age_r[index_s][w] + WAY_W'(1);
      end else begin
        age_n_s[w] = age_r[index_s][w];
      end
    end
  end

  // Next state, stall and load data; stall and DataOut respond in the request cycle.
  always_comb begin
    state_n_s = state_r;
    stall     = 1'b0;
    DataOut   = '0;
    lru_upd_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s && hit_s) begin
          lru_upd_s = 1'b1;
          DataOut   = MemWrite ? '0 : line_data_r[hit_way_s][index_s][offset_s];
        end else if (req_s) begin
          stall     = 1'b1;
          state_n_s = (valid_r[index_s][victim_s] && dirty_r[index_s][victim_s]) ? WRITEBACK : REFILL;
        end else begin
          state_n_s = IDLE;
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        state_n_s = last_s ? REFILL : WRITEBACK;
      end
      REFILL: begin
        stall     = 1'b1;
        lru_upd_s = last_s;
        state_n_s = last_s ? IDLE : REFILL;
      end
      default: state_n_s = IDLE;
    endcase
  end

  // Control state, line status bits, LRU ages and performance counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      victim_r        <= '0;
      retry_r         <= 1'b0;
      lat_cnt_r       <= '0;
      word_cnt_r      <= '0;
      hit_count       <= 32'd0;
      miss_count      <= 32'd0;
      writeback_count <= 32'd0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
          dirty_r[s][w] <= 1'b0;
          age_r[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      state_r <= state_n_s;
      if (lru_upd_s) begin
        for (int w = 0; w < WAYS; w++) begin
          age_r[index_s][w] <= age_n_s[w];
        end
      end
      case (state_r)
        IDLE: begin
          lat_cnt_r  <= '0;
          word_cnt_r <= '0;
          if (req_s && hit_s) begin
            hit_count <= retry_r ? hit_count : hit_count + 32'd1;
            retry_r   <= 1'b0;
            if (MemWrite) dirty_r[index_s][hit_way_s] <= 1'b1;
          end else if (req_s) begin
            miss_count <= miss_count + 32'd1;
            victim_r   <= victim_s;
          end
        end
        WRITEBACK, REFILL: begin
          if (word_end_s) begin
            lat_cnt_r  <= '0;
            word_cnt_r <= word_cnt_r + OFF_W'(1);
          end else begin
            lat_cnt_r <= lat_cnt_r + LAT_W'(1);
          end
          if (last_s && (state_r == WRITEBACK)) writeback_count <= writeback_count + 32'd1;
          if (last_s && (state_r == REFILL)) begin
            valid_r[index_s][victim_r] <= 1'b1;
            dirty_r[index_s][victim_r] <= 1'b0;
            retry_r                    <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Cache data/tag arrays and backing memory; these hold contents across reset.
  always_ff @(posedge clock) begin
    case (state_r)
      IDLE: begin
        if (req_s && hit_s && MemWrite) line_data_r[hit_way_s][index_s][offset_s] <= DataIn;
      end
      WRITEBACK: begin
        if (word_end_s) bmem_r[wb_addr_s] <= line_data_r[victim_r][index_s][word_cnt_r];
      end
      REFILL: begin
        if (word_end_s) line_data_r[victim_r][index_s][word_cnt_r] <= bmem_r[rf_addr_s];
        if (last_s) tag_r[index_s][victim_r] <= tag_s;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_assoc_cache_memory_system.sv
// Scoreboard bench: a line-level LRU reference model predicts data, stall length
// and counters; a negedge monitor compares whenever an access completes.
module tb_assoc_cache_memory_system;
  localparam int WAYS  = 2;
  localparam int SETS  = 16;
  localparam int WPL   = 4;
  localparam int LAT   = 2;
  localparam int CLEAN = 1 + WPL * LAT;
  localparam int DIRTY = 1 + 2 * WPL * LAT;

  typedef struct {
    logic [31:0] data;
    int          stall;
    int          hits;
    int          misses;
    int          wbs;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  address = 10'd0;
  logic [31:0] DataIn = 32'd0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic        stall;
  logic [31:0] DataOut, hit_count, miss_count, writeback_count;

  logic [9:0]  address4 = 10'd0;
  logic [31:0] data4 = 32'd0;
  logic        rd4 = 1'b0, wr4 = 1'b0;
  logic        stall4;
  logic [31:0] dout4, hc4, mc4, wc4;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        sb_q [$];
  exp_t        me;
  int          stall_cnt = 0;

  logic [31:0] bmem_m  [1024];
  logic [31:0] cdata_m [1024];
  logic        dirty_m [256];
  int          set_q   [SETS][$];
  int          m_hits = 0, m_miss = 0, m_wb = 0;

  assoc_cache_memory_system u_dut (
    .clock(clock), .reset(reset), .address(address), .DataIn(DataIn),
    .MemRead(MemRead), .MemWrite(MemWrite), .stall(stall), .DataOut(DataOut),
    .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
  );

  assoc_cache_memory_system #(.WAYS(4), .MEM_LATENCY(1)) u_dut4 (
    .clock(clock), .reset(reset), .address(address4), .DataIn(data4),
    .MemRead(rd4), .MemWrite(wr4), .stall(stall4), .DataOut(dout4),
    .hit_count(hc4), .miss_count(mc4), .writeback_count(wc4)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) set_q[s].delete();
    m_hits = 0;
    m_miss = 0;
    m_wb   = 0;
  endtask

  // Sets hold lines in most-recently-used-first order; the back is the LRU line.
  task automatic model_access(input logic [9:0] a, input logic wr, input logic [31:0] d, output exp_t e);
    int line, set, tag, pos, vline;
    line = int'(a) / WPL;
    set  = line % SETS;
    tag  = line / SETS;
    pos  = -1;
    for (int i = 0; i < set_q[set].size(); i++) if (set_q[set][i] == tag) pos = i;
    e.hits = m_hits;
    if (pos >= 0) begin
      set_q[set].delete(pos);
      e.stall = 0;
      m_hits++;
    end else begin
      m_miss++;
      e.stall = CLEAN;
      if (set_q[set].size() == WAYS) begin
        vline = set_q[set].pop_back() * SETS + set;
        if (dirty_m[vline]) begin
          for (int k = 0; k < WPL; k++) bmem_m[vline*WPL+k] = cdata_m[vline*WPL+k];
          m_wb++;
          e.stall = DIRTY;
        end
      end
      for (int k = 0; k < WPL; k++) cdata_m[line*WPL+k] = bmem_m[line*WPL+k];
      dirty_m[line] = 1'b0;
    end
    set_q[set].push_front(tag);
    if (wr) begin
      cdata_m[a]    = d;
      dirty_m[line] = 1'b1;
      e.data        = 32'd0;
    end else begin
      e.data = cdata_m[a];
    end
    e.misses = m_miss;
    e.wbs    = m_wb;
  endtask

  task automatic access(input logic [9:0] a, input logic rd, input logic wr, input logic [31:0] d);
    exp_t e;
    int   n;
    model_access(a, wr, d, e);
    sb_q.push_back(e);
    address  = a;
    DataIn   = d;
    MemRead  = rd;
    MemWrite = wr;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (stall && n < 40);
    if (stall) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout: addr 0x%03h still stalled after %0d cycles", a, n);
    end
    @(posedge clock);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic access4(input logic [9:0] a, input int exp_stall);
    int n;
    n        = 0;
    address4 = a;
    rd4      = 1'b1;
    @(negedge clock);
    while (stall4 && n < 20) begin
      n++;
      @(negedge clock);
    end
    check("ways4_stall_cycles", 32'(n), 32'(exp_stall));
    check("ways4_DataOut", dout4, 32'd0);
    @(posedge clock);
    #1;
    rd4 = 1'b0;
  endtask

  // Monitor: counts stall cycles and scores each completed access against the queue.
  always @(negedge clock) begin
    if (!reset) begin
      stall_cnt = 0;
    end else if (MemRead || MemWrite) begin
      if (stall) begin
        stall_cnt++;
      end else if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_completion: addr 0x%03h with empty scoreboard", address);
        stall_cnt = 0;
      end else begin
        me = sb_q.pop_front();
        check("DataOut", DataOut, me.data);
        check("stall_cycles", 32'(stall_cnt), 32'(me.stall));
        check("hit_count", hit_count, 32'(me.hits));
        check("miss_count", miss_count, 32'(me.misses));
        check("writeback_count", writeback_count, 32'(me.wbs));
        stall_cnt = 0;
      end
    end else begin
      check("idle_stall", {31'd0, stall}, 32'd0);
      check("idle_DataOut", DataOut, 32'd0);
      stall_cnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bmem_m[i]  = 32'd0;
      cdata_m[i] = 32'd0;
    end
    for (int i = 0; i < 256; i++) dirty_m[i] = 1'b0;
    model_reset();

    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_DataOut", DataOut, 32'd0);
    check("reset_hit_count", hit_count, 32'd0);
    check("reset_miss_count", miss_count, 32'd0);
    check("reset_writeback_count", writeback_count, 32'd0);
    @(posedge clock);
    #1;

    access(10'h000, 1'b1, 1'b0, 32'd0);
    access(10'h005, 1'b0, 1'b1, 32'h12345678);
    access(10'h005, 1'b1, 1'b0, 32'd0);
    access(10'h000, 1'b0, 1'b1, 32'hDEADBEEF);
    access(10'h040, 1'b1, 1'b0, 32'd0);
    access(10'h080, 1'b1, 1'b0, 32'd0);
    access(10'h000, 1'b1, 1'b0, 32'd0);

    // Abort a clean refill during its fourth cycle.
    address = 10'h100;
    MemRead = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    reset   = 1'b0;
    MemRead = 1'b0;
    #1;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_hit_count", hit_count, 32'd0);
    check("abort_miss_count", miss_count, 32'd0);
    check("abort_writeback_count", writeback_count, 32'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    access(10'h100, 1'b1, 1'b0, 32'd0);

    access(10'h000, 1'b1, 1'b0, 32'd0);
    access(10'h040, 1'b1, 1'b0, 32'd0);
    access(10'h000, 1'b1, 1'b0, 32'd0);
    access(10'h080, 1'b1, 1'b0, 32'd0);
    access(10'h000, 1'b1, 1'b0, 32'd0);

    for (int t = 0; t < 300; t++) begin
      logic [9:0]  a;
      logic [31:0] d;
      int          op;
      a  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
      d  = $urandom;
      op = $urandom_range(0, 9);
      if (op < 5)      access(a, 1'b1, 1'b0, d);
      else if (op < 9) access(a, 1'b0, 1'b1, d);
      else             access(a, 1'b1, 1'b1, d);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clock);
        #1;
      end
    end

    check("final_hit_count", hit_count, 32'(m_hits));
    check("final_miss_count", miss_count, 32'(m_miss));
    check("final_writeback_count", writeback_count, 32'(m_wb));
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    access4(10'h000, 5);
    access4(10'h040, 5);
    access4(10'h080, 5);
    access4(10'h0C0, 5);
    access4(10'h000, 0);
    access4(10'h040, 0);
    access4(10'h080, 0);
    access4(10'h0C0, 0);
    check("ways4_hit_count", hc4, 32'd4);
    check("ways4_miss_count", mc4, 32'd4);
    check("ways4_writeback_count", wc4, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
